// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU with registered outputs, iterative multiply into hi/lo, divide when SEQ_ALU_DIV_EN is defined.
// Latency 1 clock for single-cycle ops, WIDTH+2 for MUL/DIV; ready is low while iterating and start is then ignored.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] porta,
  input  logic [WIDTH-1:0] portb,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} aluState_t;
  aluState_t state;

  logic [WIDTH-1:0]   addRes, subRes, scRes, magA, magB, opB;
  logic [WIDTH-1:0]   fixHi, fixLo;
  logic               scOvf, signA, signB, isMul, startIter, negProd;
  logic [2*WIDTH-1:0] prod, prodNext, mulNext, prodNeg;
  logic [WIDTH:0]     mulSum;
  logic [CW-1:0]      count;

  assign addRes = porta + portb;
  assign subRes = porta - portb;
  // Odd MUL/DIV opcodes are the signed variants; iterate on magnitudes.
  assign signA = aluop[0] & porta[WIDTH-1];
  assign signB = aluop[0] & portb[WIDTH-1];
  assign magA  = signA ? -porta : porta;
  assign magB  = signB ? -portb : portb;
  assign isMul = (aluop == 4'hA) || (aluop == 4'hB);

  always_comb begin
    scRes = '0;
    scOvf = 1'b0;
    case (aluop)
      4'h0: scRes = porta << portb[SW-1:0];
      4'h1: scRes = porta >> portb[SW-1:0];
      4'h2: begin
        scRes = addRes;
        scOvf = (porta[WIDTH-1] == portb[WIDTH-1]) && (addRes[WIDTH-1] != porta[WIDTH-1]);
      end
      4'h3: begin
        scRes = subRes;
        scOvf = (porta[WIDTH-1] != portb[WIDTH-1]) && (subRes[WIDTH-1] != porta[WIDTH-1]);
      end
      4'h4: scRes = porta & portb;
      4'h5: scRes = porta | portb;
      4'h6: scRes = porta ^ portb;
      4'h7: scRes = ~(porta | portb);
      4'h8: scRes = {{(WIDTH-1){1'b0}}, ($signed(porta) < $signed(portb))};
      4'h9: scRes = {{(WIDTH-1){1'b0}}, (porta < portb)};
      default: scRes = '0;
    endcase
  end

  // Shift-add: upper half accumulates, multiplier drains out of the lower half.
  assign mulSum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opB} : '0);
  assign mulNext = {mulSum, prod[WIDTH-1:1]};
  assign prodNeg = -prod;
  assign fixLo   = negProd ? prodNeg[WIDTH-1:0] : prod[WIDTH-1:0];

`ifdef SEQ_ALU_DIV_EN
  logic               isDivOp, divZero, isDiv, negRem;
  logic [WIDTH:0]     divShift, divDiff;
  logic [2*WIDTH-1:0] divNext;

  assign isDivOp   = (aluop == 4'hC) || (aluop == 4'hD);
  assign divZero   = isDivOp && (portb == '0);
  assign startIter = isMul || (isDivOp && !divZero);
  // Restoring divide: prod holds {remainder, dividend/quotient}.
  assign divShift  = prod[2*WIDTH-1:WIDTH-1];
  assign divDiff   = divShift - {1'b0, opB};
  assign divNext   = divDiff[WIDTH] ? {divShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                    : {divDiff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  assign prodNext  = isDiv ? divNext : mulNext;
  assign fixHi     = isDiv ? (negRem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH])
                           : (negProd ? prodNeg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH]);
`else
  assign startIter = isMul;
  assign prodNext  = mulNext;
  assign fixHi     = negProd ? prodNeg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      ready        <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      negative     <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b1;
      hi           <= '0;
      lo           <= '0;
      prod         <= '0;
      opB          <= '0;
      count        <= '0;
      negProd      <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      isDiv        <= 1'b0;
      negRem       <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (startIter) begin
              state   <= BUSY;
              ready   <= 1'b0;
              count   <= CW'(WIDTH);
              prod    <= {{WIDTH{1'b0}}, magA};
              opB     <= magB;
              negProd <= signA ^ signB;
`ifdef SEQ_ALU_DIV_EN
              isDiv   <= isDivOp;
              negRem  <= signA;
            end else if (divZero) begin
              result       <= '1;
              lo           <= '1;
              hi           <= porta;
              negative     <= 1'b1;
              zero         <= 1'b0;
              overflow     <= 1'b0;
              result_valid <= 1'b1;
`endif
            end else begin
              result       <= scRes;
              negative     <= scRes[WIDTH-1];
              zero         <= (scRes == '0);
              overflow     <= scOvf;
              result_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          prod  <= prodNext;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          hi           <= fixHi;
          lo           <= fixLo;
          result       <= fixLo;
          negative     <= fixLo[WIDTH-1];
          zero         <= (fixLo == '0);
          overflow     <= 1'b0;
          result_valid <= 1'b1;
          ready        <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=32: reset, single-cycle table, MUL/DIV table, back-to-back issue.
module tb_seq_alu;

  logic        CLK = 1'b0;
  logic        nRST, start, ready, result_valid, negative, overflow, zero;
  logic [3:0]  aluop;
  logic [31:0] porta, portb, result, hi, lo;

  int total = 0;
  int bad = 0;
  int lat;
  logic seen;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } scVec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
    int          lat;
  } mdVec_t;

  scVec_t scTab[15];
  mdVec_t mdTab[2];
  mdVec_t dvTab[6];

  seq_alu #(.WIDTH(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .ready(ready), .aluop(aluop),
    .porta(porta), .portb(portb), .result(result), .result_valid(result_valid),
    .negative(negative), .overflow(overflow), .zero(zero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  function automatic scVec_t mkSc(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                  logic [31:0] res, logic ovf);
    scVec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf;
    return v;
  endfunction

  function automatic mdVec_t mkMd(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                  logic [31:0] h, logic [31:0] l, logic [31:0] res, int lt);
    mdVec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = h; v.lo = l; v.res = res; v.lat = lt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one request and counts edges from the accepting edge (=1) to result_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit pulseBusy, output int latency);
    @(negedge CLK);
    start = 1'b1; aluop = op; porta = a; portb = b;
    @(posedge CLK);
    latency = 1;
    #1;
    while (!result_valid && latency < 100) begin
      @(negedge CLK);
      start = pulseBusy && (latency == 3 || latency == 10 || latency == 20);
      aluop = 4'h2;
      @(posedge CLK);
      latency++;
      #1;
    end
    start = 1'b0;
  endtask

  task automatic checkOut(input string tag, input logic [31:0] expRes, input logic expOvf,
                          input logic [31:0] expHi, input logic [31:0] expLo,
                          input int expLat, input int gotLat);
    chk({tag, ".lat"}, 32'(gotLat), 32'(expLat));
    chk({tag, ".result"}, result, expRes);
    chk({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
    chk({tag, ".negative"}, 32'(negative), 32'(expRes[31]));
    chk({tag, ".zero"}, 32'(zero), 32'(expRes == 32'h0));
    chk({tag, ".hi"}, hi, expHi);
    chk({tag, ".lo"}, lo, expLo);
    chk({tag, ".ready"}, 32'(ready), 32'h1);
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; aluop = 4'h0; porta = '0; portb = '0;

    scTab[0]  = mkSc(4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
    scTab[1]  = mkSc(4'h3, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
    scTab[2]  = mkSc(4'h3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
    scTab[3]  = mkSc(4'h3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1);
    scTab[4]  = mkSc(4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    scTab[5]  = mkSc(4'h0, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0);
    scTab[6]  = mkSc(4'h1, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0);
    scTab[7]  = mkSc(4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0);
    scTab[8]  = mkSc(4'h5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0);
    scTab[9]  = mkSc(4'h6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0);
    scTab[10] = mkSc(4'h7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    scTab[11] = mkSc(4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    scTab[12] = mkSc(4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    scTab[13] = mkSc(4'hE, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
    scTab[14] = mkSc(4'hF, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 1'b0);

    mdTab[0] = mkMd(4'hB, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFA, 34);
    mdTab[1] = mkMd(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 34);

`ifdef SEQ_ALU_DIV_EN
    dvTab[0] = mkMd(4'hD, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 34);
    dvTab[1] = mkMd(4'hD, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFD, 34);
    dvTab[2] = mkMd(4'hD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000, 34);
    dvTab[3] = mkMd(4'hC, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 32'h0000000E, 34);
    dvTab[4] = mkMd(4'hC, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    dvTab[5] = mkMd(4'hD, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
`else
    // Divide opcodes are reserved here: hi/lo keep the last MULTU product.
    dvTab[0] = mkMd(4'hD, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 32'h0, 1);
    dvTab[1] = mkMd(4'hD, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000001, 32'h0, 1);
    dvTab[2] = mkMd(4'hD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h0, 1);
    dvTab[3] = mkMd(4'hC, 32'h00000064, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'h0, 1);
    dvTab[4] = mkMd(4'hC, 32'h0000000A, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 32'h0, 1);
    dvTab[5] = mkMd(4'hD, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 32'h0, 1);
`endif

    repeat (2) @(posedge CLK);
    #1;
    chk("rst.ready", 32'(ready), 32'h1);
    chk("rst.result", result, 32'h0);
    chk("rst.zero", 32'(zero), 32'h1);
    chk("rst.negative", 32'(negative), 32'h0);
    chk("rst.overflow", 32'(overflow), 32'h0);
    chk("rst.valid", 32'(result_valid), 32'h0);
    chk("rst.hi", hi, 32'h0);
    chk("rst.lo", lo, 32'h0);
    @(negedge CLK) nRST = 1'b1;

    issue(4'hB, 32'h00000007, 32'hFFFFFFFB, 1'b1, lat);
    checkOut("mult7xm5", 32'hFFFFFFDD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFDD, 34, lat);

    // Asynchronous reset in the middle of a MULTU.
    @(negedge CLK);
    start = 1'b1; aluop = 4'hA; porta = 32'hFFFFFFFF; portb = 32'hFFFFFFFF;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (10) @(posedge CLK);
    #1 chk("busy.ready", 32'(ready), 32'h0);
    #2 nRST = 1'b0;
    #1;
    chk("midrst.ready", 32'(ready), 32'h1);
    chk("midrst.result", result, 32'h0);
    chk("midrst.zero", 32'(zero), 32'h1);
    chk("midrst.negative", 32'(negative), 32'h0);
    chk("midrst.hi", hi, 32'h0);
    chk("midrst.lo", lo, 32'h0);
    @(negedge CLK) nRST = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1 if (result_valid) seen = 1'b1;
    end
    chk("midrst.noValid", 32'(seen), 32'h0);

    foreach (mdTab[i]) begin
      issue(mdTab[i].op, mdTab[i].a, mdTab[i].b, 1'b1, lat);
      checkOut($sformatf("md%0d", i), mdTab[i].res, 1'b0, mdTab[i].hi, mdTab[i].lo, mdTab[i].lat, lat);
    end

    foreach (scTab[i]) begin
      issue(scTab[i].op, scTab[i].a, scTab[i].b, 1'b0, lat);
      checkOut($sformatf("sc%0d", i), scTab[i].res, scTab[i].ovf, 32'hFFFFFFFE, 32'h00000001, 1, lat);
    end

    // Back-to-back single-cycle ops, start held high across three edges.
    @(negedge CLK);
    start = 1'b1; aluop = 4'h0; porta = 32'h1; portb = 32'h4;
    @(posedge CLK);
    #1 chk("b2b0.valid", 32'(result_valid), 32'h1);
    chk("b2b0.result", result, 32'h10);
    @(negedge CLK);
    aluop = 4'h8; porta = 32'hFFFFFFFF; portb = 32'h1;
    @(posedge CLK);
    #1 chk("b2b1.valid", 32'(result_valid), 32'h1);
    chk("b2b1.result", result, 32'h1);
    @(negedge CLK);
    aluop = 4'h9;
    @(posedge CLK);
    #1 chk("b2b2.valid", 32'(result_valid), 32'h1);
    chk("b2b2.result", result, 32'h0);
    start = 1'b0;
    @(posedge CLK);
    #1 chk("b2b.idleValid", 32'(result_valid), 32'h0);

    foreach (dvTab[i]) begin
      issue(dvTab[i].op, dvTab[i].a, dvTab[i].b, 1'b1, lat);
      checkOut($sformatf("dv%0d", i), dvTab[i].res, 1'b0, dvTab[i].hi, dvTab[i].lo, dvTab[i].lat, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
